// File: rtl/ex_pipe_ctrl_if.sv
// Bundle of ID-stage, ALU and write-back signals around the execute-stage controller.
// The slave modport is the controller; the master modport is whatever drives it (ID stage/ALU/bench).
interface ex_pipe_ctrl_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic          id_op;
    logic [2:0]    id_alu_func;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [RW-1:0] id_rs_a;
    logic [RW-1:0] id_rs_b;
    logic [RW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_flag_en;
    logic [DW-1:0] alu_y;
    logic          alu_z;
    logic          alu_cy;
    logic          ex_op;
    logic [2:0]    ex_alu_func;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic          p_z;
    logic          p_cy;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_we;

    modport master (
        output stall, flush, id_valid, id_op, id_alu_func, id_a, id_b,
               id_rs_a, id_rs_b, id_rd, id_wr_en, id_flag_en,
               alu_y, alu_z, alu_cy,
        input  ex_op, ex_alu_func, ex_a, ex_b, p_z, p_cy, wb_rd, wb_data, wb_we
    );

    modport slave (
        input  stall, flush, id_valid, id_op, id_alu_func, id_a, id_b,
               id_rs_a, id_rs_b, id_rd, id_wr_en, id_flag_en,
               alu_y, alu_z, alu_cy,
        output ex_op, ex_alu_func, ex_a, ex_b, p_z, p_cy, wb_rd, wb_data, wb_we
    );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage controller: ID/EX and EX/WB registers, Z/CY flag register,
// operand forwarding from WB and write-strobe gating under stall/flush.
module ex_pipe_ctrl #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic               clk,
    input  logic               rst,
    ex_pipe_ctrl_if.slave      bus
);
    logic          r_ex_valid;
    logic          r_ex_op;
    logic [2:0]    r_ex_alu_func;
    logic [DW-1:0] r_ex_a;
    logic [DW-1:0] r_ex_b;
    logic [RW-1:0] r_ex_rs_a;
    logic [RW-1:0] r_ex_rs_b;
    logic [RW-1:0] r_ex_rd;
    logic          r_ex_wr_en;
    logic          r_ex_flag_en;

    logic          r_wb_valid;
    logic          r_wb_en;
    logic [RW-1:0] r_wb_rd;
    logic [DW-1:0] r_wb_data;

    logic          r_p_z;
    logic          r_p_cy;

    logic          w_wb_we;
    logic          w_wb_live;
    logic          w_fwd_a;
    logic          w_fwd_b;
    logic          w_cap_a;
    logic          w_cap_b;
    logic [DW-1:0] w_id_a;
    logic [DW-1:0] w_id_b;

    // WB forwarding into EX, and a capture bypass for the instruction two behind,
    // whose register-file read happened before the write landed.
    assign w_wb_live = r_wb_valid & r_wb_en;
    assign w_wb_we   = w_wb_live & ~bus.stall;
    assign w_fwd_a   = w_wb_live & (r_wb_rd == r_ex_rs_a);
    assign w_fwd_b   = w_wb_live & (r_wb_rd == r_ex_rs_b);
    assign w_cap_a   = w_wb_we & (r_wb_rd == bus.id_rs_a);
    assign w_cap_b   = w_wb_we & (r_wb_rd == bus.id_rs_b);
    assign w_id_a    = w_cap_a ? r_wb_data : bus.id_a;
    assign w_id_b    = w_cap_b ? r_wb_data : bus.id_b;

    assign bus.ex_op       = r_ex_op;
    assign bus.ex_alu_func = r_ex_alu_func;
    assign bus.ex_a        = w_fwd_a ? r_wb_data : r_ex_a;
    assign bus.ex_b        = w_fwd_b ? r_wb_data : r_ex_b;
    assign bus.p_z         = r_p_z;
    assign bus.p_cy        = r_p_cy;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_we       = w_wb_we;

    // ID/EX register: flush wins over stall and turns the slot into a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_op       <= 1'b0;
            r_ex_alu_func <= 3'b000;
            r_ex_a        <= {DW{1'b0}};
            r_ex_b        <= {DW{1'b0}};
            r_ex_rs_a     <= {RW{1'b0}};
            r_ex_rs_b     <= {RW{1'b0}};
            r_ex_rd       <= {RW{1'b0}};
            r_ex_wr_en    <= 1'b0;
            r_ex_flag_en  <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid    <= 1'b0;
        end else if (!bus.stall) begin
            r_ex_valid    <= bus.id_valid;
            r_ex_op       <= bus.id_op;
            r_ex_alu_func <= bus.id_alu_func;
            r_ex_a        <= w_id_a;
            r_ex_b        <= w_id_b;
            r_ex_rs_a     <= bus.id_rs_a;
            r_ex_rs_b     <= bus.id_rs_b;
            r_ex_rd       <= bus.id_rd;
            r_ex_wr_en    <= bus.id_wr_en;
            r_ex_flag_en  <= bus.id_flag_en;
        end else begin
            r_ex_valid    <= r_ex_valid;
        end
    end

    // EX/WB result register and flag register, both frozen by stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= {RW{1'b0}};
            r_wb_data  <= {DW{1'b0}};
            r_p_z      <= 1'b0;
            r_p_cy     <= 1'b0;
        end else if (!bus.stall) begin
            r_wb_valid <= r_ex_valid;
            r_wb_en    <= r_ex_wr_en;
            r_wb_rd    <= r_ex_rd;
            r_wb_data  <= bus.alu_y;
            if (r_ex_valid && r_ex_flag_en) begin
                r_p_z  <= bus.alu_z;
                r_p_cy <= bus.alu_cy;
            end else begin
                r_p_z  <= r_p_z;
                r_p_cy <= r_p_cy;
            end
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed bench for ex_pipe_ctrl with a small behavioural ALU closing the EX loop.
module tb_ex_pipe_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   failed;
    logic [16:0] alu_t;

    ex_pipe_ctrl_if #(.DW(16), .RW(3)) bus ();

    ex_pipe_ctrl #(.DW(16), .RW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // ALU stand-in: 000 pass B, 001 ADD, 010 ADC, 011 SUB (cy = borrow), others XOR
    always_comb begin
        alu_t = 17'd0;
        case ({bus.ex_op, bus.ex_alu_func})
            4'b0000: alu_t = {1'b0, bus.ex_b};
            4'b0001: alu_t = {1'b0, bus.ex_a} + {1'b0, bus.ex_b};
            4'b0010: alu_t = {1'b0, bus.ex_a} + {1'b0, bus.ex_b} + {16'd0, bus.p_cy};
            4'b0011: alu_t = {1'b0, bus.ex_a} - {1'b0, bus.ex_b};
            default: alu_t = {1'b0, bus.ex_a ^ bus.ex_b};
        endcase
        bus.alu_y  = alu_t[15:0];
        bus.alu_z  = (alu_t[15:0] == 16'd0);
        bus.alu_cy = alu_t[16];
    end

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic drive_id(input logic op, input logic [2:0] func, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] rsa, input logic [2:0] rsb,
                            input logic [2:0] rd, input logic we, input logic fe);
        bus.id_valid    = 1'b1;
        bus.id_op       = op;
        bus.id_alu_func = func;
        bus.id_a        = a;
        bus.id_b        = b;
        bus.id_rs_a     = rsa;
        bus.id_rs_b     = rsb;
        bus.id_rd       = rd;
        bus.id_wr_en    = we;
        bus.id_flag_en  = fe;
    endtask

    task automatic idle_id();
        bus.id_valid   = 1'b0;
        bus.id_wr_en   = 1'b0;
        bus.id_flag_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (bus.ex_a !== 16'h0000) begin failed++; $display("FAIL reset_ex_a: got %h expected %h", bus.ex_a, 16'h0000); end
        tests++; if (bus.ex_b !== 16'h0000) begin failed++; $display("FAIL reset_ex_b: got %h expected %h", bus.ex_b, 16'h0000); end
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL reset_wb_we: got %b expected %b", bus.wb_we, 1'b0); end
        tests++; if (bus.wb_data !== 16'h0000) begin failed++; $display("FAIL reset_wb_data: got %h expected %h", bus.wb_data, 16'h0000); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b00) begin failed++; $display("FAIL reset_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b00); end
        tests++; if ({bus.ex_op, bus.ex_alu_func} !== 4'b0000) begin failed++; $display("FAIL reset_ex_ctl: got %b expected %b", {bus.ex_op, bus.ex_alu_func}, 4'b0000); end
    endtask

    task automatic test_add_flags();
        drive_id(1'b0, 3'b001, 16'hFFFF, 16'h0001, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1);
        tick();
        idle_id();
        tick();
        tests++; if (bus.wb_data !== 16'h0000) begin failed++; $display("FAIL add_wb_data: got %h expected %h", bus.wb_data, 16'h0000); end
        tests++; if (bus.wb_we !== 1'b1) begin failed++; $display("FAIL add_wb_we: got %b expected %b", bus.wb_we, 1'b1); end
        tests++; if (bus.wb_rd !== 3'd3) begin failed++; $display("FAIL add_wb_rd: got %0d expected %0d", bus.wb_rd, 3'd3); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL add_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
        tick();
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL add_we_once: got %b expected %b", bus.wb_we, 1'b0); end
    endtask

    task automatic test_back_to_back();
        drive_id(1'b0, 3'b000, 16'h0000, 16'h1234, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 3'b001, 16'h0000, 16'h0000, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0);
        tick();
        tests++; if (bus.ex_a !== 16'h1234) begin failed++; $display("FAIL fwd_ex_a: got %h expected %h", bus.ex_a, 16'h1234); end
        tests++; if (bus.ex_b !== 16'h1234) begin failed++; $display("FAIL fwd_ex_b: got %h expected %h", bus.ex_b, 16'h1234); end
        drive_id(1'b0, 3'b001, 16'h0000, 16'h0001, 3'd1, 3'd5, 3'd4, 1'b1, 1'b0);
        tick();
        tests++; if (bus.wb_data !== 16'h2468) begin failed++; $display("FAIL chain_wb_data: got %h expected %h", bus.wb_data, 16'h2468); end
        tests++; if (bus.ex_a !== 16'h1234) begin failed++; $display("FAIL capture_ex_a: got %h expected %h", bus.ex_a, 16'h1234); end
        tests++; if (bus.ex_b !== 16'h0001) begin failed++; $display("FAIL capture_ex_b: got %h expected %h", bus.ex_b, 16'h0001); end
        idle_id();
        tick();
        tests++; if (bus.wb_data !== 16'h1235) begin failed++; $display("FAIL capture_result: got %h expected %h", bus.wb_data, 16'h1235); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL chain_flags_hold: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
    endtask

    task automatic test_adc_chain();
        drive_id(1'b0, 3'b001, 16'h8000, 16'h8000, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1);
        tick();
        drive_id(1'b0, 3'b010, 16'h0001, 16'h0000, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1);
        tick();
        tests++; if (bus.wb_data !== 16'h0000) begin failed++; $display("FAIL adc_first_data: got %h expected %h", bus.wb_data, 16'h0000); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL adc_first_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
        idle_id();
        tick();
        tests++; if (bus.wb_data !== 16'h0002) begin failed++; $display("FAIL adc_result: got %h expected %h", bus.wb_data, 16'h0002); end
        tests++; if (bus.wb_rd !== 3'd6) begin failed++; $display("FAIL adc_wb_rd: got %0d expected %0d", bus.wb_rd, 3'd6); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b00) begin failed++; $display("FAIL adc_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b00); end
        tick();
    endtask

    task automatic test_stall();
        drive_id(1'b0, 3'b000, 16'h0000, 16'hABCD, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 3'b001, 16'h0000, 16'h5433, 3'd2, 3'd0, 3'd3, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 3'b111, 16'h7777, 16'h7777, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1);
        bus.stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL stall_wb_we[%0d]: got %b expected %b", i, bus.wb_we, 1'b0); end
            tests++; if (bus.ex_a !== 16'hABCD) begin failed++; $display("FAIL stall_ex_a[%0d]: got %h expected %h", i, bus.ex_a, 16'hABCD); end
            tests++; if ({bus.p_z, bus.p_cy} !== 2'b00) begin failed++; $display("FAIL stall_flags[%0d]: got %b expected %b", i, {bus.p_z, bus.p_cy}, 2'b00); end
            tick();
        end
        bus.stall = 1'b0;
        idle_id();
        #1;
        tests++; if (bus.wb_we !== 1'b1) begin failed++; $display("FAIL stall_release_we: got %b expected %b", bus.wb_we, 1'b1); end
        tests++; if (bus.wb_data !== 16'hABCD) begin failed++; $display("FAIL stall_release_data: got %h expected %h", bus.wb_data, 16'hABCD); end
        tick();
        tests++; if (bus.wb_rd !== 3'd3) begin failed++; $display("FAIL stall_next_rd: got %0d expected %0d", bus.wb_rd, 3'd3); end
        tests++; if (bus.wb_data !== 16'h0000) begin failed++; $display("FAIL stall_next_data: got %h expected %h", bus.wb_data, 16'h0000); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL stall_next_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
        tick();
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL stall_bubble_we: got %b expected %b", bus.wb_we, 1'b0); end
    endtask

    task automatic test_flush();
        drive_id(1'b0, 3'b011, 16'h0003, 16'h0005, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle_id();
        #1;
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL flush_we_0: got %b expected %b", bus.wb_we, 1'b0); end
        tick();
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL flush_we_1: got %b expected %b", bus.wb_we, 1'b0); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL flush_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
        drive_id(1'b0, 3'b000, 16'h0000, 16'h0F0F, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0);
        tick();
        idle_id();
        tick();
        drive_id(1'b0, 3'b011, 16'h0003, 16'h0005, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        #1;
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL sf_we_low: got %b expected %b", bus.wb_we, 1'b0); end
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        idle_id();
        #1;
        tests++; if (bus.wb_we !== 1'b1) begin failed++; $display("FAIL sf_wb_held_we: got %b expected %b", bus.wb_we, 1'b1); end
        tests++; if (bus.wb_data !== 16'h0F0F) begin failed++; $display("FAIL sf_wb_held_data: got %h expected %h", bus.wb_data, 16'h0F0F); end
        tick();
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL sf_bubble_we: got %b expected %b", bus.wb_we, 1'b0); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b11) begin failed++; $display("FAIL sf_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b11); end
    endtask

    task automatic test_reset_mid();
        drive_id(1'b0, 3'b001, 16'h0001, 16'h0002, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1);
        tick();
        idle_id();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL rstmid_we: got %b expected %b", bus.wb_we, 1'b0); end
        tests++; if ({bus.p_z, bus.p_cy} !== 2'b00) begin failed++; $display("FAIL rstmid_flags: got %b expected %b", {bus.p_z, bus.p_cy}, 2'b00); end
        tests++; if (bus.ex_a !== 16'h0000) begin failed++; $display("FAIL rstmid_ex_a: got %h expected %h", bus.ex_a, 16'h0000); end
        tests++; if (bus.wb_rd !== 3'd0) begin failed++; $display("FAIL rstmid_wb_rd: got %0d expected %0d", bus.wb_rd, 3'd0); end
        tick();
        tests++; if (bus.wb_we !== 1'b0) begin failed++; $display("FAIL rstmid_we_after: got %b expected %b", bus.wb_we, 1'b0); end
    endtask

    initial begin
        tests           = 0;
        failed          = 0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_op       = 1'b0;
        bus.id_alu_func = 3'b000;
        bus.id_a        = 16'h0000;
        bus.id_b        = 16'h0000;
        bus.id_rs_a     = 3'd0;
        bus.id_rs_b     = 3'd0;
        bus.id_rd       = 3'd0;
        bus.id_wr_en    = 1'b0;
        bus.id_flag_en  = 1'b0;
        test_reset();
        test_add_flags();
        test_back_to_back();
        test_adc_chain();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ex_pipe_ctrl.md
# ex_pipe_ctrl

Execute-stage pipeline controller for the 16-bit RISC core; sits directly upstream of the ALU and feeds it. It holds the ID/EX register (opcode class, function, operands, destination) and the EX/WB result register. It owns the architectural Z/CY flag register that drives the ALU's `p_Z`/`p_CY` inputs, and it resolves read-after-write hazards by operand forwarding. It also gates the register-file write strobe under stall and flush.

## Interface
Parameters:
- `DW`, 16, datapath width
- `RW`, 3, register-address width (8 GPRs)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  freeze EX and WB registers this cycle
- `flush`  in  1  convert the instruction entering EX into a bubble
- `id_valid`  in  1  ID stage presents an instruction
- `id_op`  in  1  ALU group select (0 = arithmetic, 1 = logic/rotate)
- `id_alu_func`  in  3  ALU function code
- `id_a`, `id_b`  in  DW  register-file read data
- `id_rs_a`, `id_rs_b`  in  RW  source register numbers of `id_a`/`id_b`
- `id_rd`  in  RW  destination register
- `id_wr_en`  in  1  instruction writes `id_rd`
- `id_flag_en`  in  1  instruction updates Z/CY
- `alu_y`  in  DW  ALU result
- `alu_z`, `alu_cy`  in  1  ALU flag outputs
- `ex_op`  out  1  to ALU `op`
- `ex_alu_func`  out  3  to ALU `ALU_func`
- `ex_a`, `ex_b`  out  DW  forwarded operands to ALU `A`/`B`
- `p_z`, `p_cy`  out  1  flag register, to ALU `p_Z`/`p_CY`
- `wb_rd`  out  RW  write-back register number
- `wb_data`  out  DW  write-back data
- `wb_we`  out  1  register-file write strobe

## Operation
EX register contents: `ex_valid`, `ex_op`, `ex_alu_func`, `ex_a_r`, `ex_b_r`, `ex_rs_a`, `ex_rs_b`, `ex_rd`, `ex_wr_en`, `ex_flag_en`.

WB register contents: `wb_valid`, `wb_en`, `wb_rd`, `wb_data`.

Per rising edge, when `rst`=0:
- EX load:
  - If `flush`=1, `ex_valid` <= 0; other EX fields are don't-care.
  - Else if `stall`=1, EX holds.
  - Else EX <= ID fields with `ex_valid` <= `id_valid`.
- Capture bypass applies when EX loads. If `wb_we`=1 and `wb_rd`==`id_rs_a`, then `ex_a_r` <= `wb_data`, otherwise `id_a`. `ex_b_r` follows the same rule with `id_rs_b`.
- WB load:
  - If `stall`=1, WB holds, regardless of `flush`.
  - Else `wb_valid` <= `ex_valid`, `wb_en` <= `ex_wr_en`, `wb_rd` <= `ex_rd`, `wb_data` <= `alu_y`.
- Flags: if `stall`=0, `ex_valid`=1 and `ex_flag_en`=1, then {`p_z`,`p_cy`} <= {`alu_z`,`alu_cy`}. Otherwise the flags hold. Bubbles never touch the flags.

Combinational:
- `ex_a` = `wb_data` if (`wb_valid` & `wb_en` & `wb_rd`==`ex_rs_a`), else `ex_a_r`. `ex_b` uses the same rule with `ex_rs_b`.
- `wb_we` = `wb_valid` & `wb_en` & ~`stall`. Each retired write is therefore strobed exactly once, in the first non-stalled cycle it occupies WB.

Register 0 is not special; forwarding applies to all RW-bit addresses.

All arithmetic belongs to the ALU. This block adds and truncates nothing; widths pass through unchanged.

## Timing
- Reset (`rst`=1 at an edge) clears every register to zero: `ex_valid`, `ex_op`, `ex_alu_func`, `ex_a_r`, `ex_b_r`, `wb_valid`, `wb_rd`, `wb_data`, `p_z`, `p_cy`. Outputs after reset are `ex_a`=`ex_b`=0, `wb_we`=0. Reset overrides `stall`/`flush` and aborts in-flight instructions with no write strobe.
- Latency:
  - Instruction accepted at edge N executes in cycle N..N+1.
  - Result and flags are registered at edge N+1.
  - `wb_we` is high during cycle N+1..N+2 (absent stall).
- Back-to-back dependents need zero stall cycles. A dependent one instruction behind uses EX forwarding. A dependent two behind uses the capture bypass.
- Flags updated at edge N+1 are visible to the next instruction's ALU evaluation, so ADC/SBB/RCL/RCR chains need no bubbles.
- ALU path (30 ns gate delay) must settle within one clock period. The bench uses a 50 ns period minimum.
- When `stall` and `flush` are both 1: EX becomes a bubble, WB holds, flags hold, `wb_we`=0.

## Test plan
- Reset mid-stream: ADD in EX when `rst` pulses -> `wb_we` never asserts for it; `p_z`=`p_cy`=0; `ex_a`=0 next cycle.
- ADD (op=0, func=001) A=0xFFFF, B=0x0001, flag_en -> next cycle `wb_data`=0x0000, `wb_we`=1, `p_z`=1, `p_cy`=1.
- Dependency chain: R1=0x1234 written, then immediately ADD R2=R1+R1 with `id_a`=`id_b`=stale 0x0000 -> `ex_a`=`ex_b`=0x1234, `wb_data`=0x2468; third instruction reading R1 via capture bypass gets 0x1234.
- ADC after carry-producing ADD (0x8000+0x8000 then ADC 0x0001+0x0000) -> second result 0x0002, `p_cy`=0.
- Stall 3 cycles with a write in WB -> `wb_we` low for 3 cycles, then high exactly one cycle; `ex_a` forwarding value held stable throughout; flags unchanged.
- Flush with a flag-setting SUB entering EX -> no `wb_we` for it, `p_z`/`p_cy` keep previous values; same check with `stall`=1 simultaneous.
